// File: rtl/map_read_arbiter.sv
// Shares one map BRAM read port between two DDA units with a round-robin arbiter.
// A tag pipeline that matches the BRAM latency routes each returned value back to its requester, in order.
module map_read_arbiter #(
    parameter int N            = 24,
    parameter int BRAM_LATENCY = 2,
    localparam int ADDR_W      = $clog2(N*N)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic [1:0]        req_in,
    input  logic [ADDR_W-1:0] addr0_in,
    input  logic [ADDR_W-1:0] addr1_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    input  logic [3:0]        bram_data_in,
    output logic [3:0]        data_out,
    output logic [1:0]        data_valid_out,
    output logic              busy_out
);

    localparam int CELLS = N * N;

    logic [1:0]              pending_q;
    logic [1:0]              pending_d;
    logic                    ptr_q;
    logic                    iss_vld_q;
    logic                    iss_id_q;
    logic                    iss_oor_q;
    logic [BRAM_LATENCY-1:0] pipe_vld_q;
    logic [BRAM_LATENCY-1:0] pipe_id_q;
    logic [BRAM_LATENCY-1:0] pipe_oor_q;

    logic [1:0]        eligible;
    logic              grant_vld;
    logic              grant_id;
    logic [ADDR_W-1:0] win_addr;
    logic              win_oor;
    logic              exit_vld;
    logic              exit_id;
    logic              exit_oor;

    // A requester whose valid pulse is showing this cycle must wait one more cycle before re-arbitrating.
    always_comb begin
        eligible  = req_in & ~pending_q & ~data_valid_out;
        grant_vld = |eligible;
        grant_id  = (eligible == 2'b11) ? ptr_q : eligible[1];
        win_addr  = grant_id ? addr1_in : addr0_in;
        win_oor   = int'(win_addr) >= CELLS;
        exit_vld  = pipe_vld_q[BRAM_LATENCY-1];
        exit_id   = pipe_id_q[BRAM_LATENCY-1];
        exit_oor  = pipe_oor_q[BRAM_LATENCY-1];
        pending_d = pending_q;
        if (exit_vld) begin
            pending_d[exit_id] = 1'b0;
        end
        if (grant_vld) begin
            pending_d[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending_q      <= '0;
            ptr_q          <= 1'b0;
            iss_vld_q      <= 1'b0;
            iss_id_q       <= 1'b0;
            iss_oor_q      <= 1'b0;
            pipe_vld_q     <= '0;
            pipe_id_q      <= '0;
            pipe_oor_q     <= '0;
            bram_addr_out  <= '0;
            data_out       <= '0;
            data_valid_out <= '0;
        end else begin
            pending_q <= pending_d;
            iss_vld_q <= grant_vld;
            if (grant_vld) begin
                ptr_q         <= ~grant_id;
                iss_id_q      <= grant_id;
                iss_oor_q     <= win_oor;
                bram_addr_out <= win_oor ? '0 : win_addr;
            end

            // The issue stage sits alongside bram_addr_out; the tag stages then track the BRAM latency.
            pipe_vld_q[0] <= iss_vld_q;
            pipe_id_q[0]  <= iss_id_q;
            pipe_oor_q[0] <= iss_oor_q;
            for (int k = 1; k < BRAM_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_id_q[k]  <= pipe_id_q[k-1];
                pipe_oor_q[k] <= pipe_oor_q[k-1];
            end

            data_valid_out <= '0;
            if (exit_vld) begin
                data_valid_out[exit_id] <= 1'b1;
                data_out                <= exit_oor ? 4'hF : bram_data_in;
            end
        end
    end

    assign busy_out = iss_vld_q | (|pipe_vld_q);

endmodule

// File: tb/tb_map_read_arbiter.sv
// Directed bench for map_read_arbiter: BRAM latency model plus hand-computed expectations per step.
module tb_map_read_arbiter;

   localparam int N  = 24;
   localparam int L  = 2;
   localparam int AW = 10;

   logic          clock = 1'b0;
   logic          rstN;
   logic [1:0]    req;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [AW-1:0] bramAddr;
   logic [3:0]    bramData;
   logic [3:0]    dataOut;
   logic [1:0]    dataValid;
   logic          busy;

   int checks   = 0;
   int failures = 0;
   int grant0;
   int grant1;
   int diff;

   logic [3:0] bramPipe [L];

   map_read_arbiter #(.N(N), .BRAM_LATENCY(L)) dut (
      .pixel_clk_in   (clock),
      .rst_n_in       (rstN),
      .req_in         (req),
      .addr0_in       (addr0),
      .addr1_in       (addr1),
      .bram_addr_out  (bramAddr),
      .bram_data_in   (bramData),
      .data_out       (dataOut),
      .data_valid_out (dataValid),
      .busy_out       (busy)
   );

   // Free-running pixel clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Map contents: cell 25 holds 3, every other cell holds its low nibble XOR 2.
   function automatic logic [3:0] mapVal(input logic [AW-1:0] a);
      if (a == 10'd25) return 4'h3;
      return a[3:0] ^ 4'h2;
   endfunction

   // BRAM read port model: data appears L cycles after the address is presented.
   always @(posedge clock) begin
      bramPipe[0] <= mapVal(bramAddr);
      for (int k = 1; k < L; k++) bramPipe[k] <= bramPipe[k-1];
   end
   assign bramData = bramPipe[L-1];

   // Advance to just after the next rising edge(s), where outputs are sampled and inputs changed.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      rstN  = 1'b0;
      req   = 2'b00;
      addr0 = '0;
      addr1 = '0;
      applyStimulus(2);
      checkOutput("reset_addr", 32'(bramAddr), 32'd0);
      checkOutput("reset_data", 32'(dataOut), 32'd0);
      checkOutput("reset_valid", 32'(dataValid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      rstN = 1'b1;

      // Simultaneous requests straight after reset: DDA 0 first, then DDA 1.
      req = 2'b11; addr0 = 10'd5; addr1 = 10'd7;
      applyStimulus(1);
      checkOutput("sim_issue0", 32'(bramAddr), 32'd5);
      checkOutput("sim_busy", 32'(busy), 32'd1);
      applyStimulus(1);
      checkOutput("sim_issue1", 32'(bramAddr), 32'd7);
      applyStimulus(1);
      checkOutput("sim_noearly", 32'(dataValid), 32'd0);
      applyStimulus(1);
      checkOutput("sim_valid0", 32'(dataValid), 32'b01);
      checkOutput("sim_data0", 32'(dataOut), 32'h7);
      req = 2'b10;
      applyStimulus(1);
      checkOutput("sim_valid1", 32'(dataValid), 32'b10);
      checkOutput("sim_data1", 32'(dataOut), 32'h5);
      req = 2'b00;
      applyStimulus(1);
      req = 2'b11; addr0 = 10'd9; addr1 = 10'd11;
      applyStimulus(1);
      checkOutput("ptr_issue0", 32'(bramAddr), 32'd9);
      applyStimulus(1);
      checkOutput("ptr_issue1", 32'(bramAddr), 32'd11);
      req = 2'b00;
      applyStimulus(6);
      checkOutput("drain_busy", 32'(busy), 32'd0);

      // Single request with no re-issue while pending.
      req = 2'b01; addr0 = 10'd25;
      checkOutput("hold_addr", 32'(bramAddr), 32'd11);
      applyStimulus(1);
      checkOutput("single_issue", 32'(bramAddr), 32'd25);
      applyStimulus(2);
      checkOutput("single_noearly", 32'(dataValid), 32'd0);
      applyStimulus(1);
      checkOutput("single_valid", 32'(dataValid), 32'b01);
      checkOutput("single_data", 32'(dataOut), 32'h3);
      checkOutput("single_noreissue", 32'(busy), 32'd0);
      applyStimulus(1);
      checkOutput("single_pulse_end", 32'(dataValid), 32'd0);
      checkOutput("single_exit_wait", 32'(busy), 32'd0);
      req = 2'b00;
      applyStimulus(1);

      // Out-of-range address from DDA 1 reads as a wall.
      req = 2'b10; addr1 = 10'd576;
      applyStimulus(1);
      checkOutput("oor_addr", 32'(bramAddr), 32'd0);
      applyStimulus(3);
      checkOutput("oor_valid", 32'(dataValid), 32'b10);
      checkOutput("oor_data", 32'(dataOut), 32'hF);
      req = 2'b00;
      applyStimulus(2);

      // Abandoned request still completes, then DDA 0 is served again.
      req = 2'b01; addr0 = 10'd50;
      applyStimulus(1);
      checkOutput("aband_issue", 32'(bramAddr), 32'd50);
      req = 2'b00;
      applyStimulus(3);
      checkOutput("aband_valid", 32'(dataValid), 32'b01);
      checkOutput("aband_data", 32'(dataOut), 32'h0);
      applyStimulus(1);
      req = 2'b01; addr0 = 10'd51;
      applyStimulus(1);
      checkOutput("aband_reissue", 32'(bramAddr), 32'd51);
      applyStimulus(3);
      checkOutput("aband_valid2", 32'(dataValid), 32'b01);
      checkOutput("aband_data2", 32'(dataOut), 32'h1);
      req = 2'b00;
      applyStimulus(2);

      // Reset one cycle after an issue discards the read in flight.
      req = 2'b01; addr0 = 10'd30;
      applyStimulus(1);
      checkOutput("rst_issue", 32'(bramAddr), 32'd30);
      req = 2'b00;
      #2 rstN = 1'b0;
      #1;
      checkOutput("rst_async_addr", 32'(bramAddr), 32'd0);
      checkOutput("rst_async_busy", 32'(busy), 32'd0);
      checkOutput("rst_async_valid", 32'(dataValid), 32'd0);
      checkOutput("rst_async_data", 32'(dataOut), 32'd0);
      applyStimulus(2);
      rstN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1);
         checkOutput("rst_no_ghost", 32'(dataValid), 32'd0);
      end
      req = 2'b01; addr0 = 10'd40;
      applyStimulus(1);
      checkOutput("rst_new_issue", 32'(bramAddr), 32'd40);
      applyStimulus(2);
      checkOutput("rst_new_noearly", 32'(dataValid), 32'd0);
      applyStimulus(1);
      checkOutput("rst_new_valid", 32'(dataValid), 32'b01);
      checkOutput("rst_new_data", 32'(dataOut), 32'hA);
      req = 2'b00;
      applyStimulus(2);

      // Fairness with both DDAs requesting continuously.
      grant0 = 0;
      grant1 = 0;
      req = 2'b11; addr0 = 10'd60; addr1 = 10'd62;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1);
         checkOutput("fair_onehot", 32'(dataValid != 2'b11), 32'd1);
         if (dataValid == 2'b01) begin
            grant0++;
            checkOutput("fair_data0", 32'(dataOut), 32'hE);
         end
         if (dataValid == 2'b10) begin
            grant1++;
            checkOutput("fair_data1", 32'(dataOut), 32'hC);
         end
      end
      diff = (grant0 > grant1) ? grant0 - grant1 : grant1 - grant0;
      checkOutput("fair_diff", 32'(diff <= 1), 32'd1);
      checkOutput("fair_min0", 32'(grant0 >= 30), 32'd1);
      checkOutput("fair_min1", 32'(grant1 >= 30), 32'd1);
      req = 2'b00;
      applyStimulus(6);
      checkOutput("final_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
